// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, instruction field positions and enums shared by the FP issue path.
package fpu_pkg;
    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_MUL = 6'b110010;
    localparam logic [5:0] OP_DIV = 6'b110011;
    localparam logic [5:0] OP_CMP = 6'b110100;
    localparam logic [5:0] OP_REV = 6'b110101;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_LW  = 6'b110111;
    localparam logic [5:0] OP_SW  = 6'b111000;
    localparam int OP_HI = 31, OP_LO = 26;
    localparam int FS_HI = 25, FS_LO = 21;
    localparam int FT_HI = 20, FT_LO = 16;
    localparam int FD_HI = 15, FD_LO = 11;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, READ} issue_state_t;
    typedef enum logic [1:0] {CLS_ADDSUB, CLS_MULDIV, CLS_MISC} lat_class_t;
endpackage

// File: rtl/fpu_instr_decode.sv
// fpu_instr_decode: splits an FP instruction into opcode, register fields and latency class.
module fpu_instr_decode
    import fpu_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal,
    output lat_class_t  cls,
    output logic [5:0]  op,
    output logic [4:0]  fs,
    output logic [4:0]  ft,
    output logic [4:0]  fd,
    output logic        is_sw
);
    logic unused_bits;
    assign unused_bits = ^instr[FD_LO-1:0];
    assign op    = instr[OP_HI:OP_LO];
    assign fs    = instr[FS_HI:FS_LO];
    assign ft    = instr[FT_HI:FT_LO];
    assign fd    = instr[FD_HI:FD_LO];
    assign legal = op >= OP_ADD && op <= OP_SW;
    assign is_sw = op == OP_SW;
    assign cls   = (op == OP_ADD || op == OP_SUB) ? CLS_ADDSUB :
                   (op == OP_MUL || op == OP_DIV || op == OP_REV) ? CLS_MULDIV : CLS_MISC;
endmodule

// File: rtl/fpu_issue_unit.sv
// fpu_issue_unit: accepts FP instructions from the CPU, issues one-cycle coprocessor
// commands, reserves per-class latency and returns sws store data.
module fpu_issue_unit
    import fpu_pkg::*;
#(
    parameter int LAT_ADDSUB = 0,
    parameter int LAT_MULDIV = 2,
    parameter int LAT_MISC   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] ld_data,
    output logic [5:0]  cop_opcode,
    output logic [4:0]  cop_addr_in1,
    output logic [4:0]  cop_addr_in2,
    output logic [4:0]  cop_addr_dest,
    output logic [31:0] cop_indata,
    input  logic [31:0] cop_outdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        illegal,
    output logic        busy
);
    localparam int MAX_LAT = LAT_ADDSUB > LAT_MULDIV ? (LAT_ADDSUB > LAT_MISC ? LAT_ADDSUB : LAT_MISC)
                                                     : (LAT_MULDIV > LAT_MISC ? LAT_MULDIV : LAT_MISC);
    localparam int CW = MAX_LAT > 1 ? $clog2(MAX_LAT) : 1;

    issue_state_t  state;
    lat_class_t    cls_q, d_cls;
    logic          sw_q, d_legal, d_sw;
    logic [5:0]    d_op;
    logic [4:0]    d_fs, d_ft, d_fd;
    logic [CW-1:0] cnt;
    int            lat;

    fpu_instr_decode u_dec (
        .instr (instr),
        .legal (d_legal),
        .cls   (d_cls),
        .op    (d_op),
        .fs    (d_fs),
        .ft    (d_ft),
        .fd    (d_fd),
        .is_sw (d_sw)
    );

    assign instr_ready = state == IDLE;
    assign busy        = state != IDLE;

    always_comb
        lat = cls_q == CLS_MULDIV ? LAT_MULDIV : cls_q == CLS_ADDSUB ? LAT_ADDSUB : LAT_MISC;

    // cop_opcode is loaded on acceptance so it is visible exactly during ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cls_q         <= CLS_ADDSUB;
            sw_q          <= 1'b0;
            cnt           <= '0;
            cop_opcode    <= OP_NOP;
            cop_addr_in1  <= '0;
            cop_addr_in2  <= '0;
            cop_addr_dest <= '0;
            cop_indata    <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            illegal       <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE:
                    if (instr_valid) begin
                        if (d_legal) begin
                            cop_opcode    <= d_op;
                            cop_addr_in1  <= d_fs;
                            cop_addr_in2  <= d_ft;
                            cop_addr_dest <= d_fd;
                            cop_indata    <= ld_data;
                            cls_q         <= d_cls;
                            sw_q          <= d_sw;
                            state         <= ISSUE;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                ISSUE: begin
                    cop_opcode <= OP_NOP;
                    if (sw_q) begin
                        state <= READ;
                    end else if (lat > 0) begin
                        cnt   <= CW'(lat - 1);
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT:
                    if (cnt == '0) state <= IDLE;
                    else cnt <= cnt - CW'(1);
                READ: begin
                    rd_data  <= cop_outdata;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_issue_unit.sv
// tb_fpu_issue_unit: directed and random stimulus with an issue/store-data scoreboard.
module tb_fpu_issue_unit;
    import fpu_pkg::*;

    logic        clk = 0, rst = 1, instr_valid = 0;
    logic [31:0] instr = 0, ld_data = 0, cop_outdata = 0;
    logic        instr_ready, rd_valid, illegal, busy;
    logic [5:0]  cop_opcode;
    logic [4:0]  cop_addr_in1, cop_addr_in2, cop_addr_dest;
    logic [31:0] cop_indata, rd_data;

    int compared = 0, mismatched = 0;
    int cyc = 0, acc_cyc = 0, issue_count = 0, sent = 0, rd_count = 0, sws_count = 0;
    logic [31:0] store_val = 0;
    logic [52:0] issue_q[$];
    logic [31:0] rd_q[$];

    fpu_issue_unit #(.LAT_ADDSUB(0), .LAT_MULDIV(2), .LAT_MISC(0)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ld_data(ld_data), .cop_opcode(cop_opcode),
        .cop_addr_in1(cop_addr_in1), .cop_addr_in2(cop_addr_in2), .cop_addr_dest(cop_addr_dest),
        .cop_indata(cop_indata), .cop_outdata(cop_outdata), .rd_valid(rd_valid),
        .rd_data(rd_data), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every non-NOP command cycle consumes one expected issue
    always @(negedge clk) begin
        if (cop_opcode != OP_NOP) begin
            issue_count++;
            if (issue_q.size() == 0) chk("issue_unexpected", {58'd0, cop_opcode}, 64'd0);
            else chk("issue", {11'd0, cop_opcode, cop_addr_in1, cop_addr_in2, cop_addr_dest, cop_indata},
                     {11'd0, issue_q.pop_front()});
            if (cop_opcode == OP_SW) begin
                cop_outdata = store_val;
                rd_q.push_back(store_val);
            end
        end
        if (rd_valid) begin
            rd_count++;
            if (rd_q.size() == 0) chk("rd_unexpected", {32'd0, rd_data}, 64'd0);
            else chk("rd_data", {32'd0, rd_data}, {32'd0, rd_q.pop_front()});
        end
    end

    task automatic send(input logic [5:0] op, input logic [4:0] fs, input logic [4:0] ft,
                        input logic [4:0] fd, input logic [31:0] ld);
        int n = 0;
        @(negedge clk);
        instr_valid = 1;
        instr = {op, fs, ft, fd, 11'h5a5};
        ld_data = ld;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 64'd0, 64'd1);
            instr_valid = 0;
            return;
        end
        if (op >= 6'b110000 && op <= 6'b111000) begin
            issue_q.push_back({op, fs, ft, fd, ld});
            sent++;
        end
        @(posedge clk);
        acc_cyc = cyc;
        #1 instr_valid = 0;
    endtask

    initial begin
        int t0;
        logic [5:0] rop;
        repeat (2) @(negedge clk);
        chk("rst_opcode", {58'd0, cop_opcode}, 64'd0);
        chk("rst_ready", {63'd0, instr_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rd", {31'd0, rd_valid, rd_data}, 64'd0);
        rst = 0;

        send(OP_LW, 5'd3, 5'd0, 5'd0, 32'h3FC00000);
        chk("lws_op", {58'd0, cop_opcode}, {58'd0, OP_LW});
        chk("lws_in1", {59'd0, cop_addr_in1}, 64'd3);
        chk("lws_data", {32'd0, cop_indata}, 64'h3FC00000);
        chk("lws_ready_low", {63'd0, instr_ready}, 64'd0);
        @(posedge clk); #1;
        chk("lws_ready_back", {63'd0, instr_ready}, 64'd1);

        store_val = 32'h40400000;
        sws_count++;
        send(OP_ADD, 5'd1, 5'd2, 5'd4, 32'h0);
        send(OP_SW, 5'd4, 5'd0, 5'd0, 32'h0);
        t0 = rd_count;
        repeat (4) @(negedge clk);
        chk("sws_rd_once", 64'(rd_count - t0), 64'd1);
        chk("sws_rd_data", {32'd0, rd_data}, 64'h40400000);

        send(OP_DIV, 5'd5, 5'd6, 5'd7, 32'h0);
        t0 = acc_cyc;
        send(OP_ADD, 5'd8, 5'd9, 5'd10, 32'h0);
        chk("div_spacing", 64'(acc_cyc - t0), 64'd4);

        send(6'b001000, 5'd1, 5'd1, 5'd1, 32'h0);
        chk("ill_pulse", {63'd0, illegal}, 64'd1);
        chk("ill_opcode", {58'd0, cop_opcode}, 64'd0);
        chk("ill_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("ill_single", {63'd0, illegal}, 64'd0);

        send(OP_MUL, 5'd2, 5'd3, 5'd4, 32'h0);
        @(posedge clk); #1;
        chk("mul_in_wait", {63'd0, busy}, 64'd1);
        rst = 1;
        #1;
        chk("rstw_opcode", {58'd0, cop_opcode}, 64'd0);
        chk("rstw_busy", {63'd0, busy}, 64'd0);
        chk("rstw_ready", {63'd0, instr_ready}, 64'd1);
        chk("rstw_rd", {63'd0, rd_valid}, 64'd0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 1000; i++) begin
            rop = 6'b110000 + 6'($urandom_range(0, 8));
            if (rop == OP_SW) begin
                store_val = $urandom;
                sws_count++;
            end
            send(rop, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
        end
        repeat (10) @(negedge clk);
        chk("issue_drained", 64'(issue_q.size()), 64'd0);
        chk("rd_drained", 64'(rd_q.size()), 64'd0);
        chk("issue_count", 64'(issue_count), 64'(sent));
        chk("rd_count", 64'(rd_count), 64'(sws_count));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
